// File: rtl/issue_rr_scheduler.sv
// issue_rr_scheduler: arbitrates WIDTH issue-queue slots onto one functional unit, holding it for multi-cycle ops.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_request    per-slot ready-to-issue request
//   i_multi      per-slot multi-cycle flag, sampled for the granted slot only
//   i_ready      functional unit accepts the presented op this cycle
//   i_flush      synchronous flush: back to READY, no accept, pointer kept
//   o_grant      one-hot grant or zero
//   o_grant_idx  binary index of the grant, zero when no grant
//   o_valid      a grant is presented
//   o_busy       unit held by a multi-cycle op
//   o_empty      no slot is requesting
// Macro ISSUE_RR_EN: round-robin priority pointer; undefined gives fixed lowest-index priority.
module issue_rr_scheduler #(
  parameter int WIDTH     = 4,
  parameter int MULTI_LAT = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [WIDTH-1:0]         i_request,
  input  logic [WIDTH-1:0]         i_multi,
  input  logic                     i_ready,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_grant,
  output logic [$clog2(WIDTH)-1:0] o_grant_idx,
  output logic                     o_valid,
  output logic                     o_busy,
  output logic                     o_empty
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(MULTI_LAT + 1);
  typedef enum logic {READY, HOLD} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [IW-1:0] w_ptr;
  logic [IW-1:0] w_idx;
  logic          w_found;
  logic          w_valid;
  logic          w_accept;
  int            w_j;
`ifdef ISSUE_RR_EN
  logic [IW-1:0] r_ptr;
  assign w_ptr = r_ptr;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)
      r_ptr <= '0;
    else if (w_accept)
      r_ptr <= (w_idx == IW'(WIDTH - 1)) ? '0 : w_idx + 1'b1;
`else
  assign w_ptr = '0;
`endif
  // Search upward from the pointer, wrapping past the top slot.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_j     = 0;
    for (int k = 0; k < WIDTH; k++) begin
      w_j = (int'(w_ptr) + k) % WIDTH;
      if (!w_found && i_request[w_j]) begin
        w_found = 1'b1;
        w_idx   = IW'(w_j);
      end
    end
  end
  assign w_valid     = (r_state == READY) && w_found && !i_flush;
  assign w_accept    = w_valid && i_ready;
  assign o_valid     = w_valid;
  assign o_grant     = w_valid ? (WIDTH'(1) << w_idx) : '0;
  assign o_grant_idx = w_valid ? w_idx : '0;
  assign o_busy      = (r_state == HOLD);
  assign o_empty     = ~|i_request;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= READY;
      r_cnt   <= '0;
    end else if (i_flush) begin
      r_state <= READY;
      r_cnt   <= '0;
    end else if (r_state == HOLD) begin
      if (r_cnt == '0)
        r_state <= READY;
      else
        r_cnt <= r_cnt - 1'b1;
    end else if (w_accept && i_multi[w_idx]) begin
      r_state <= HOLD;
      r_cnt   <= CW'(MULTI_LAT - 1);
    end
endmodule

// File: tb/tb_issue_rr_scheduler.sv
// tb_issue_rr_scheduler: directed scoreboard bench for issue_rr_scheduler (WIDTH=4, MULTI_LAT=4).
module tb_issue_rr_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] multi = '0;
  logic       rdy = 1'b0;
  logic       fl = 1'b0;
  logic [3:0] grant;
  logic [1:0] gidx;
  logic       valid, busy, empty;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic       v;
    logic [3:0] g;
    logic [1:0] idx;
    logic       busy;
    logic       empty;
  } exp_t;
  exp_t q[$];
  bit m_hold = 1'b0;
  int m_cnt = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  issue_rr_scheduler #(.WIDTH(4), .MULTI_LAT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(req), .i_multi(multi),
    .i_ready(rdy), .i_flush(fl), .o_grant(grant), .o_grant_idx(gidx),
    .o_valid(valid), .o_busy(busy), .o_empty(empty)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [3:0] r, input logic [3:0] m, input logic rd, input logic f);
    exp_t e;
    int idx;
    bit found;
    req = r; multi = m; rdy = rd; fl = f;
    found = 1'b0;
    idx = 0;
    for (int k = 0; k < 4; k++)
      if (!found && r[(m_ptr + k) % 4]) begin
        found = 1'b1;
        idx = (m_ptr + k) % 4;
      end
    e.v     = !m_hold && found && !f;
    e.idx   = e.v ? idx[1:0] : 2'd0;
    e.g     = e.v ? (4'b0001 << idx) : 4'b0000;
    e.busy  = m_hold;
    e.empty = (r == 4'b0000);
    q.push_back(e);
    #1;
    e = q.pop_front();
    chk({tag, ".valid"}, {3'b0, valid}, {3'b0, e.v});
    chk({tag, ".grant"}, grant, e.g);
    chk({tag, ".idx"}, {2'b0, gidx}, {2'b0, e.idx});
    chk({tag, ".busy"}, {3'b0, busy}, {3'b0, e.busy});
    chk({tag, ".empty"}, {3'b0, empty}, {3'b0, e.empty});
    @(posedge clk);
    if (!rst_n) begin
      m_hold = 1'b0; m_cnt = 0; m_ptr = 0;
    end else if (f) begin
      m_hold = 1'b0; m_cnt = 0;
    end else if (m_hold) begin
      if (m_cnt == 0) m_hold = 1'b0;
      else m_cnt--;
    end else if (e.v && rd) begin
`ifdef ISSUE_RR_EN
      m_ptr = (idx + 1) % 4;
`endif
      if (m[idx]) begin
        m_hold = 1'b1;
        m_cnt = 3;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    drive("reset", 4'b0000, 4'b0000, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) drive("rr", 4'b1111, 4'b0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive("bp_stall", 4'b0110, 4'b0000, 1'b0, 1'b0);
    drive("bp_accept", 4'b0110, 4'b0000, 1'b1, 1'b0);
    drive("bp_next", 4'b0110, 4'b0000, 1'b0, 1'b0);
    drive("multi_acc", 4'b0100, 4'b0100, 1'b1, 1'b0);
    drive("hold1", 4'b0000, 4'b0000, 1'b1, 1'b0);
    drive("hold2", 4'b0000, 4'b0000, 1'b1, 1'b0);
    drive("hold3", 4'b1111, 4'b0000, 1'b1, 1'b0);
    drive("hold4", 4'b1111, 4'b0000, 1'b1, 1'b0);
    drive("post_hold", 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive("multi_acc2", 4'b1000, 4'b1000, 1'b1, 1'b0);
    drive("fl_hold1", 4'b1111, 4'b0000, 1'b1, 1'b0);
    drive("fl_hold2", 4'b1111, 4'b0000, 1'b1, 1'b1);
    drive("post_flush", 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive("flush_ready", 4'b1111, 4'b1111, 1'b1, 1'b1);
    drive("after_flush", 4'b1111, 4'b0000, 1'b0, 1'b0);
    drive("to_ptr3", 4'b0100, 4'b0000, 1'b1, 1'b0);
    drive("wrap", 4'b0001, 4'b0000, 1'b1, 1'b0);
    drive("empty", 4'b0000, 4'b0000, 1'b1, 1'b0);
    drive("multi_acc3", 4'b0010, 4'b0010, 1'b1, 1'b0);
    req = 4'b0000; multi = 4'b0000; rdy = 1'b0;
    #1;
    chk("pre_reset.busy", {3'b0, busy}, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.busy", {3'b0, busy}, 4'd0);
    chk("async_rst.valid", {3'b0, valid}, 4'd0);
    chk("async_rst.idx", {2'b0, gidx}, 4'd0);
    m_hold = 1'b0; m_cnt = 0; m_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive("rst_grant3", 4'b1000, 4'b0000, 1'b1, 1'b0);
    drive("rst_ptr0", 4'b1111, 4'b0000, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
